dmac_host_master: RTL and testbench

Bus initiator driving the DMAC slave register port: accepts one transfer command, programs the slave's source, destination, size, opmode and interrupt-enable registers, starts the operation, then waits for completion via interrupt or status polling and clears `opdone`. It sits between the control core (command side) and the DMAC slave (`s_sel`/`s_wr`/`s_addr`/`s_din`/`s_dout`), owning the register-access sequence.

---
 rtl/dmac_pkg.sv | 32 +++
 rtl/dmac_host_master.sv | 272 +++++++++++++++++++++++++++
 tb/tb_dmac_host_master.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmac_pkg.sv
// -----------------------------------------------------------------------------
// dmac_pkg
// Definitions shared by the DMAC host master and the DMAC slave register port.
//   - Register addresses of the slave register port.
//   - State encoding of the host-master sequencer.
// -----------------------------------------------------------------------------
package dmac_pkg;

    localparam logic [15:0] ADDR_START      = 16'h0000;  // write 1 to start
    localparam logic [15:0] ADDR_INTERRUPT  = 16'h0001;  // rd bit0 = opdone, wr 1 = clear
    localparam logic [15:0] ADDR_INT_ENABLE = 16'h0002;
    localparam logic [15:0] ADDR_SOURCE     = 16'h0003;
    localparam logic [15:0] ADDR_DEST       = 16'h0004;
    localparam logic [15:0] ADDR_SIZE       = 16'h0005;
    localparam logic [15:0] ADDR_OPMODE     = 16'h0007;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WR_SRC   = 4'd1,
        ST_WR_DEST  = 4'd2,
        ST_WR_SIZE  = 4'd3,
        ST_WR_MODE  = 4'd4,
        ST_WR_IE    = 4'd5,
        ST_WR_START = 4'd6,
        ST_WAIT     = 4'd7,
        ST_POLL_RD  = 4'd8,
        ST_POLL_CHK = 4'd9,
        ST_CLEAR    = 4'd10,
        ST_FIN      = 4'd11
    } hm_state_e;

endpackage

// File: rtl/dmac_host_master.sv
// -----------------------------------------------------------------------------
// dmac_host_master
// Bus initiator for the DMAC slave register port. Takes one transfer command,
// programs source/destination/size/opmode/interrupt-enable, starts the
// operation, waits for completion (interrupt or status polling), clears
// opdone and reports done/err.
//
// Ports
//   clk, reset_n                   clock, async active-low reset
//   cmd_valid/cmd_ready            command handshake (ready only in IDLE)
//   cmd_src/dest/size/opmode/ie    command fields
//   m_sel/m_wr/m_addr/m_dout       register access to the slave
//   m_din                          slave read data (one-cycle latency)
//   m_irq                          slave interrupt
//   busy/done/err                  status; err is meaningful with done
//
// state       | meaning
// ------------+----------------------------------------------------------
// IDLE        | ready for a command
// WR_SRC      | source write on the bus
// WR_DEST     | destination write on the bus
// WR_SIZE     | size write on the bus
// WR_MODE     | opmode write on the bus
// WR_IE       | interrupt-enable write on the bus
// WR_START    | start write on the bus, timeout loaded
// WAIT        | waiting for irq (ie=1) or for the poll gap (ie=0)
// POLL_RD     | status read on the bus
// POLL_CHK    | status read data sampled
// CLEAR       | opdone clear write on the bus
// FIN         | done pulse
//
// All outputs are registered: the bus values shown while in a state are
// computed on the edge that enters that state.
// -----------------------------------------------------------------------------
module dmac_host_master
    import dmac_pkg::*;
#(
    parameter int unsigned POLL_GAP = 4,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_src,
    input  logic [31:0] cmd_dest,
    input  logic [31:0] cmd_size,
    input  logic [1:0]  cmd_opmode,
    input  logic        cmd_ie,
    output logic        m_sel,
    output logic        m_wr,
    output logic [15:0] m_addr,
    output logic [31:0] m_dout,
    input  logic [31:0] m_din,
    input  logic        m_irq,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [GW-1:0] GAP_LOAD = GW'(POLL_GAP - 1);
    // Counter runs through 0 inclusive; the WR_START cycle and the final
    // transition cycle account for the remaining two counts.
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 2);

    hm_state_e     state_q, state_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          m_sel_q, m_sel_d;
    logic          m_wr_q, m_wr_d;
    logic [15:0]   m_addr_q, m_addr_d;
    logic [31:0]   m_dout_q, m_dout_d;
    logic [31:0]   dest_q, dest_d;
    logic [31:0]   size_q, size_d;
    logic [1:0]    opmode_q, opmode_d;
    logic          ie_q, ie_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [TW-1:0] tmo_q, tmo_d;

    // Only the opdone bit of the status word matters.
    logic          din_unused;
    assign din_unused = ^m_din[31:1];

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        m_sel_d     = 1'b0;
        m_wr_d      = 1'b0;
        m_addr_d    = m_addr_q;
        m_dout_d    = m_dout_q;
        dest_d      = dest_q;
        size_d      = size_q;
        opmode_d    = opmode_q;
        ie_d        = ie_q;
        gap_d       = gap_q;
        tmo_d       = tmo_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    dest_d      = cmd_dest;
                    size_d      = cmd_size;
                    opmode_d    = cmd_opmode;
                    ie_d        = cmd_ie;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    err_d       = 1'b0;
                    if (cmd_size == 32'd0) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d  = ST_WR_SRC;
                        m_sel_d  = 1'b1;
                        m_wr_d   = 1'b1;
                        m_addr_d = ADDR_SOURCE;
                        m_dout_d = cmd_src;
                    end
                end
            end
            ST_WR_SRC: begin
                state_d  = ST_WR_DEST;
                m_sel_d  = 1'b1;
                m_wr_d   = 1'b1;
                m_addr_d = ADDR_DEST;
                m_dout_d = dest_q;
            end
            ST_WR_DEST: begin
                state_d  = ST_WR_SIZE;
                m_sel_d  = 1'b1;
                m_wr_d   = 1'b1;
                m_addr_d = ADDR_SIZE;
                m_dout_d = size_q;
            end
            ST_WR_SIZE: begin
                state_d  = ST_WR_MODE;
                m_sel_d  = 1'b1;
                m_wr_d   = 1'b1;
                m_addr_d = ADDR_OPMODE;
                m_dout_d = {30'b0, opmode_q};
            end
            ST_WR_MODE: begin
                state_d  = ST_WR_IE;
                m_sel_d  = 1'b1;
                m_wr_d   = 1'b1;
                m_addr_d = ADDR_INT_ENABLE;
                m_dout_d = {31'b0, ie_q};
            end
            ST_WR_IE: begin
                state_d  = ST_WR_START;
                m_sel_d  = 1'b1;
                m_wr_d   = 1'b1;
                m_addr_d = ADDR_START;
                m_dout_d = 32'd1;
            end
            ST_WR_START: begin
                state_d = ST_WAIT;
                tmo_d   = TMO_LOAD;
                gap_d   = GAP_LOAD;
            end
            ST_WAIT, ST_POLL_RD, ST_POLL_CHK: begin
                // Timeout wins over any coincident irq or poll hit.
                if (tmo_q == '0) begin
                    state_d  = ST_CLEAR;
                    err_d    = 1'b1;
                    m_sel_d  = 1'b1;
                    m_wr_d   = 1'b1;
                    m_addr_d = ADDR_INTERRUPT;
                    m_dout_d = 32'd1;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                    if (state_q == ST_WAIT) begin
                        if (ie_q) begin
                            if (m_irq) begin
                                state_d  = ST_CLEAR;
                                m_sel_d  = 1'b1;
                                m_wr_d   = 1'b1;
                                m_addr_d = ADDR_INTERRUPT;
                                m_dout_d = 32'd1;
                            end
                        end else if (gap_q == '0) begin
                            // Read keeps m_dout at its last written value.
                            state_d  = ST_POLL_RD;
                            m_sel_d  = 1'b1;
                            m_addr_d = ADDR_INTERRUPT;
                        end else begin
                            gap_d = gap_q - 1'b1;
                        end
                    end else if (state_q == ST_POLL_RD) begin
                        state_d = ST_POLL_CHK;
                    end else if (m_din[0]) begin
                        state_d  = ST_CLEAR;
                        m_sel_d  = 1'b1;
                        m_wr_d   = 1'b1;
                        m_addr_d = ADDR_INTERRUPT;
                        m_dout_d = 32'd1;
                    end else begin
                        state_d = ST_WAIT;
                        gap_d   = GAP_LOAD;
                    end
                end
            end
            ST_CLEAR: begin
                state_d = ST_FIN;
                done_d  = 1'b1;
            end
            ST_FIN: begin
                state_d     = ST_IDLE;
                busy_d      = 1'b0;
                cmd_ready_d = 1'b1;
            end
            default: begin
                state_d     = ST_IDLE;
                busy_d      = 1'b0;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            m_sel_q     <= 1'b0;
            m_wr_q      <= 1'b0;
            m_addr_q    <= '0;
            m_dout_q    <= '0;
            dest_q      <= '0;
            size_q      <= '0;
            opmode_q    <= '0;
            ie_q        <= 1'b0;
            gap_q       <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            m_sel_q     <= m_sel_d;
            m_wr_q      <= m_wr_d;
            m_addr_q    <= m_addr_d;
            m_dout_q    <= m_dout_d;
            dest_q      <= dest_d;
            size_q      <= size_d;
            opmode_q    <= opmode_d;
            ie_q        <= ie_d;
            gap_q       <= gap_d;
            tmo_q       <= tmo_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign m_sel     = m_sel_q;
    assign m_wr      = m_wr_q;
    assign m_addr    = m_addr_q;
    assign m_dout    = m_dout_q;

endmodule

// File: tb/tb_dmac_host_master.sv
module tb_dmac_host_master;
    import dmac_pkg::*;

    typedef struct {
        int          cyc;
        logic        wr;
        logic [15:0] addr;
        logic [31:0] data;
    } bus_t;

    typedef struct {
        int   cyc;
        logic err;
    } done_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic [31:0] cmd_src, cmd_dest, cmd_size;
    logic [1:0]  cmd_opmode;
    logic        cmd_ie;
    logic [31:0] m_din = 32'd0;
    logic        m_irq = 1'b0;
    logic        use_t;

    // main instance (default parameters)
    logic        a_valid, a_ready, a_sel, a_wr, a_busy, a_done, a_err;
    logic [15:0] a_addr;
    logic [31:0] a_dout;
    // short-timeout instance
    logic        t_valid, t_irq, t_ready, t_sel, t_wr, t_busy, t_done, t_err;
    logic [15:0] t_addr;
    logic [31:0] t_dout;

    logic        mon_ready, mon_sel, mon_wr, mon_busy, mon_done, mon_err;
    logic [15:0] mon_addr;
    logic [31:0] mon_dout;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   irq_delay = -1;
    int   poll_hit = 0;
    int   start_cyc = -1000;
    int   rd_cnt = 0;
    logic rd_pend = 1'b0;
    logic rd_resp = 1'b0;
    int   acc;
    bus_t  exp_bus[$];
    done_t exp_done[$];
    bus_t  mon_e;
    done_t mon_d;

    assign a_valid = cmd_valid & ~use_t;
    assign t_valid = cmd_valid & use_t;
    assign t_irq   = m_irq & use_t;

    assign mon_ready = use_t ? t_ready : a_ready;
    assign mon_sel   = use_t ? t_sel   : a_sel;
    assign mon_wr    = use_t ? t_wr    : a_wr;
    assign mon_addr  = use_t ? t_addr  : a_addr;
    assign mon_dout  = use_t ? t_dout  : a_dout;
    assign mon_busy  = use_t ? t_busy  : a_busy;
    assign mon_done  = use_t ? t_done  : a_done;
    assign mon_err   = use_t ? t_err   : a_err;

    dmac_host_master dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(a_valid), .cmd_ready(a_ready),
        .cmd_src(cmd_src), .cmd_dest(cmd_dest), .cmd_size(cmd_size),
        .cmd_opmode(cmd_opmode), .cmd_ie(cmd_ie),
        .m_sel(a_sel), .m_wr(a_wr), .m_addr(a_addr), .m_dout(a_dout),
        .m_din(m_din), .m_irq(m_irq),
        .busy(a_busy), .done(a_done), .err(a_err)
    );

    dmac_host_master #(.POLL_GAP(4), .TIMEOUT(16)) dut_tmo (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(t_valid), .cmd_ready(t_ready),
        .cmd_src(cmd_src), .cmd_dest(cmd_dest), .cmd_size(cmd_size),
        .cmd_opmode(cmd_opmode), .cmd_ie(cmd_ie),
        .m_sel(t_sel), .m_wr(t_wr), .m_addr(t_addr), .m_dout(t_dout),
        .m_din(m_din), .m_irq(t_irq),
        .busy(t_busy), .done(t_done), .err(t_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at t=%0t", tag, obs, exp_v, $time);
        end
    endtask

    // Slave model: irq raised irq_delay cycles after the start write and held
    // until the clear write; status reads answer one cycle later, opdone set
    // on the poll_hit-th read.
    always @(negedge clk) begin
        if (mon_sel && mon_wr && mon_addr == ADDR_START) begin
            start_cyc = cyc;
            rd_cnt    = 0;
        end
        if (mon_sel && mon_wr && mon_addr == ADDR_INTERRUPT && mon_dout[0])
            m_irq = 1'b0;
        else if (irq_delay >= 0 && cyc == start_cyc + irq_delay)
            m_irq = 1'b1;
        m_din = rd_pend ? {31'b0, rd_resp} : 32'd0;
        if (mon_sel && !mon_wr && mon_addr == ADDR_INTERRUPT) begin
            rd_cnt++;
            rd_pend = 1'b1;
            rd_resp = (rd_cnt == poll_hit);
        end else begin
            rd_pend = 1'b0;
        end
    end

    // Bus / completion monitor against the scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            if (mon_sel) begin
                if (exp_bus.size() == 0) begin
                    chk("bus_unexpected", 32'(exp_bus.size()), 32'd1);
                end else begin
                    mon_e = exp_bus.pop_front();
                    chk("bus_cycle", 32'(cyc), 32'(mon_e.cyc));
                    chk("bus_wr", {31'b0, mon_wr}, {31'b0, mon_e.wr});
                    chk("bus_addr", {16'b0, mon_addr}, {16'b0, mon_e.addr});
                    chk("bus_data", mon_dout, mon_e.data);
                end
            end else if (mon_wr) begin
                chk("wr_outside_access", {31'b0, mon_wr}, 32'd0);
            end
            if (mon_done) begin
                if (exp_done.size() == 0) begin
                    chk("done_unexpected", 32'(exp_done.size()), 32'd1);
                end else begin
                    mon_d = exp_done.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(mon_d.cyc));
                    chk("done_err", {31'b0, mon_err}, {31'b0, mon_d.err});
                end
            end
            if (mon_busy) chk("ready_low_while_busy", {31'b0, mon_ready}, 32'd0);
        end
    end

    task automatic exp_b(input int c, input logic wr, input logic [15:0] a, input logic [31:0] d);
        bus_t b;
        b.cyc = c; b.wr = wr; b.addr = a; b.data = d;
        exp_bus.push_back(b);
    endtask

    task automatic exp_dn(input int c, input logic e);
        done_t d;
        d.cyc = c; d.err = e;
        exp_done.push_back(d);
    endtask

    // Programming writes: spec cycle k is seen at bench cycle acc_c + k - 1.
    task automatic exp_cmd(input int acc_c, input logic [31:0] src, dest, size,
                           input logic [1:0] op, input logic ie);
        exp_b(acc_c,     1'b1, ADDR_SOURCE,     src);
        exp_b(acc_c + 1, 1'b1, ADDR_DEST,       dest);
        exp_b(acc_c + 2, 1'b1, ADDR_SIZE,       size);
        exp_b(acc_c + 3, 1'b1, ADDR_OPMODE,     {30'b0, op});
        exp_b(acc_c + 4, 1'b1, ADDR_INT_ENABLE, {31'b0, ie});
        exp_b(acc_c + 5, 1'b1, ADDR_START,      32'd1);
    endtask

    task automatic send(input logic [31:0] src, dest, size, input logic [1:0] op,
                        input logic ie, input bit hold, output int acc_c);
        int n = 0;
        @(negedge clk);
        cmd_src = src; cmd_dest = dest; cmd_size = size; cmd_opmode = op; cmd_ie = ie;
        cmd_valid = 1'b1;
        while (!mon_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!mon_ready) chk("accept_wait", {31'b0, mon_ready}, 32'd1);
        @(posedge clk);
        #1;
        acc_c = cyc;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_bus.size() != 0 || exp_done.size() != 0 || mon_busy) && n < max_cyc);
        if (n >= max_cyc) chk("idle_bound", 32'(exp_bus.size() + exp_done.size()), 32'd0);
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_m_sel"},     {31'b0, mon_sel},   32'd0);
        chk({pfx, "_m_wr"},      {31'b0, mon_wr},    32'd0);
        chk({pfx, "_m_addr"},    {16'b0, mon_addr},  32'd0);
        chk({pfx, "_m_dout"},    mon_dout,           32'd0);
        chk({pfx, "_cmd_ready"}, {31'b0, mon_ready}, 32'd1);
        chk({pfx, "_busy"},      {31'b0, mon_busy},  32'd0);
        chk({pfx, "_done"},      {31'b0, mon_done},  32'd0);
        chk({pfx, "_err"},       {31'b0, mon_err},   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; use_t = 1'b0;
        cmd_src = '0; cmd_dest = '0; cmd_size = '0; cmd_opmode = '0; cmd_ie = 1'b0;
        #12;
        chk_reset_vals("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // interrupt completion, irq 20 cycles after start
        irq_delay = 20;
        send(32'h1000, 32'h2000, 32'd8, 2'd2, 1'b1, 1'b0, acc);
        exp_cmd(acc, 32'h1000, 32'h2000, 32'd8, 2'd2, 1'b1);
        exp_b(acc + 26, 1'b1, ADDR_INTERRUPT, 32'd1);
        exp_dn(acc + 27, 1'b0);
        wait_idle(200);

        // polled completion, opdone on third poll (POLL_GAP = 4)
        irq_delay = -1;
        poll_hit  = 3;
        send(32'h1000, 32'h2000, 32'd8, 2'd2, 1'b0, 1'b0, acc);
        exp_cmd(acc, 32'h1000, 32'h2000, 32'd8, 2'd2, 1'b0);
        for (int i = 0; i < 3; i++) exp_b(acc + 10 + 6 * i, 1'b0, ADDR_INTERRUPT, 32'd1);
        exp_b(acc + 24, 1'b1, ADDR_INTERRUPT, 32'd1);
        exp_dn(acc + 25, 1'b0);
        wait_idle(200);

        // size-zero reject: no bus access, done/err at cycle 1
        send(32'hAAAA, 32'hBBBB, 32'd0, 2'd1, 1'b1, 1'b0, acc);
        exp_dn(acc, 1'b1);
        wait_idle(20);

        // timeout with irq never asserted (TIMEOUT = 16)
        @(negedge clk);
        use_t = 1'b1;
        send(32'h3000, 32'h4000, 32'd4, 2'd1, 1'b1, 1'b0, acc);
        exp_cmd(acc, 32'h3000, 32'h4000, 32'd4, 2'd1, 1'b1);
        exp_b(acc + 21, 1'b1, ADDR_INTERRUPT, 32'd1);
        exp_dn(acc + 22, 1'b1);
        wait_idle(100);
        @(negedge clk);
        use_t = 1'b0;

        // asynchronous reset while waiting, then a normal command
        send(32'h5000, 32'h6000, 32'd16, 2'd3, 1'b1, 1'b0, acc);
        exp_cmd(acc, 32'h5000, 32'h6000, 32'd16, 2'd3, 1'b1);
        while (cyc < acc + 12) @(negedge clk);
        chk("busy_before_reset", {31'b0, mon_busy}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        irq_delay = 3;
        send(32'h7000, 32'h8000, 32'd2, 2'd0, 1'b1, 1'b0, acc);
        exp_cmd(acc, 32'h7000, 32'h8000, 32'd2, 2'd0, 1'b1);
        exp_b(acc + 9, 1'b1, ADDR_INTERRUPT, 32'd1);
        exp_dn(acc + 10, 1'b0);
        wait_idle(100);

        // cmd_valid held through done: second command taken the cycle after done
        irq_delay = 5;
        send(32'h9000, 32'hA000, 32'd5, 2'd1, 1'b1, 1'b1, acc);
        cmd_size = 32'd0;
        exp_cmd(acc, 32'h9000, 32'hA000, 32'd5, 2'd1, 1'b1);
        exp_b(acc + 11, 1'b1, ADDR_INTERRUPT, 32'd1);
        exp_dn(acc + 12, 1'b0);
        exp_dn(acc + 14, 1'b1);
        while (cyc < acc + 14) @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle(50);

        chk("bus_left", 32'(exp_bus.size()), 32'd0);
        chk("done_left", 32'(exp_done.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
